// File: rtl/latency_stats_pkg.sv
// Shared widths, the per-sample pipeline record and the saturating increment
// used by every statistics counter.
package latency_stats_pkg;

  localparam int unsigned DEF_DATA_W    = 256;
  localparam int unsigned DEF_TS_W      = 64;
  localparam int unsigned DEF_CNT_W     = 32;
  localparam int unsigned DEF_SUM_W     = 64;
  localparam int unsigned DEF_NUM_BINS  = 16;
  localparam int unsigned DEF_BIN_SHIFT = 4;
  localparam int unsigned MAX_W         = 64;

  typedef struct packed {
    logic [DEF_TS_W-1:0] delta;
    logic                valid;
    logic                neg;
  } lat_sample_t;

  // Increment v, treating it as a w-bit counter that sticks at all-ones.
  function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v, input int unsigned w);
    logic [MAX_W-1:0] lim;
    lim = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    return (v >= lim) ? v : v + MAX_W'(1);
  endfunction

endpackage

// File: rtl/latency_stats_collector_if.sv
// Record stream handshake bundle (data, valid, ready, last).
interface latency_stats_collector_if
  import latency_stats_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/latency_histogram.sv
// Linear latency histogram: clamped bin select, saturating per-bin counters,
// synchronous clear and a registered read port returning pre-update contents.
module latency_histogram
  import latency_stats_pkg::*;
#(
  parameter int unsigned NUM_BINS  = DEF_NUM_BINS,
  parameter int unsigned BIN_SHIFT = DEF_BIN_SHIFT,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned TS_W      = DEF_TS_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_clear,
  input  logic                        i_inc_en,
  input  logic [TS_W-1:0]             i_delta,
  input  logic [$clog2(NUM_BINS)-1:0] i_rd_addr,
  output logic [CNT_W-1:0]            o_rd_data
);

  logic [TS_W-1:0]             w_bin_raw;
  logic [$clog2(NUM_BINS)-1:0] w_bin;
  logic [CNT_W-1:0]            r_bins [NUM_BINS];
  logic [CNT_W-1:0]            r_rd_data;

  // Anything at or beyond the last bin boundary lands in the overflow bin.
  assign w_bin_raw = i_delta >> BIN_SHIFT;
  assign w_bin     = (w_bin_raw >= TS_W'(NUM_BINS - 1)) ? ($clog2(NUM_BINS))'(NUM_BINS - 1)
                                                        : w_bin_raw[$clog2(NUM_BINS)-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_BINS; i++) r_bins[i] <= '0;
    end else if (i_clear) begin
      for (int unsigned i = 0; i < NUM_BINS; i++) r_bins[i] <= '0;
    end else if (i_inc_en) begin
      r_bins[w_bin] <= CNT_W'(sat_inc(MAX_W'(r_bins[w_bin]), CNT_W));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= r_bins[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/latency_stats_collector.sv
// Forwards event records through one register stage with their latency in tuser,
// and keeps min/max/sum/count/negative statistics plus a latency histogram.
module latency_stats_collector
  import latency_stats_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned TS_W      = DEF_TS_W,
  parameter int unsigned TS_LSB    = 0,
  parameter int unsigned NUM_BINS  = DEF_NUM_BINS,
  parameter int unsigned BIN_SHIFT = DEF_BIN_SHIFT,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned SUM_W     = DEF_SUM_W
) (
  input  logic                        clk,
  input  logic                        rst,
  latency_stats_collector_if.slave    s_axis,
  input  logic [TS_W-1:0]             pl_now,
  latency_stats_collector_if.master   m_axis,
  output logic [TS_W-1:0]             m_axis_tuser,
  input  logic                        clear,
  input  logic                        freeze,
  input  logic [$clog2(NUM_BINS)-1:0] rd_addr,
  output logic [CNT_W-1:0]            rd_data,
  output logic [TS_W-1:0]             stat_min,
  output logic [TS_W-1:0]             stat_max,
  output logic [SUM_W-1:0]            stat_sum,
  output logic [CNT_W-1:0]            stat_count,
  output logic [CNT_W-1:0]            stat_neg_count
);

  logic              w_accept;
  logic              w_ts_ok;
  logic [TS_W-1:0]   w_ts;
  logic [TS_W-1:0]   w_delta;
  logic [TS_W-1:0]   w_smp_delta;
  logic              w_upd_valid;
  logic              w_upd_neg;
  logic [SUM_W:0]    w_sum_ext;

  logic              r_tvalid;
  logic              r_tlast;
  logic [DATA_W-1:0] r_tdata;
  logic [TS_W-1:0]   r_tuser;
  lat_sample_t       r_smp;
  logic [TS_W-1:0]   r_min;
  logic [TS_W-1:0]   r_max;
  logic [SUM_W-1:0]  r_sum;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_neg_count;

  assign s_axis.tready = !r_tvalid || m_axis.tready;
  assign w_accept      = s_axis.tvalid && s_axis.tready;
  assign w_ts          = s_axis.tdata[TS_LSB +: TS_W];
  assign w_ts_ok       = pl_now >= w_ts;
  assign w_delta       = w_ts_ok ? (pl_now - w_ts) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_tuser  <= '0;
    end else if (s_axis.tready) begin
      r_tvalid <= s_axis.tvalid;
      if (w_accept) begin
        r_tdata <= s_axis.tdata;
        r_tuser <= w_delta;
        r_tlast <= s_axis.tlast;
      end
    end
  end

  // Sample stage decouples statistics from downstream backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_smp <= '0;
    end else begin
      r_smp.delta <= DEF_TS_W'(w_delta);
      r_smp.valid <= w_accept && w_ts_ok;
      r_smp.neg   <= w_accept && !w_ts_ok;
    end
  end

  assign w_smp_delta = TS_W'(r_smp.delta);
  assign w_upd_valid = r_smp.valid && !freeze;
  assign w_upd_neg   = r_smp.neg && !freeze;
  assign w_sum_ext   = {1'b0, r_sum} + (SUM_W + 1)'(w_smp_delta);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min       <= '1;
      r_max       <= '0;
      r_sum       <= '0;
      r_count     <= '0;
      r_neg_count <= '0;
    end else if (clear) begin
      r_min       <= '1;
      r_max       <= '0;
      r_sum       <= '0;
      r_count     <= '0;
      r_neg_count <= '0;
    end else begin
      if (w_upd_valid) begin
        r_count <= CNT_W'(sat_inc(MAX_W'(r_count), CNT_W));
        r_sum   <= w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
        if (w_smp_delta < r_min) r_min <= w_smp_delta;
        if (w_smp_delta > r_max) r_max <= w_smp_delta;
      end
      if (w_upd_neg) r_neg_count <= CNT_W'(sat_inc(MAX_W'(r_neg_count), CNT_W));
    end
  end

  latency_histogram #(
    .NUM_BINS  (NUM_BINS),
    .BIN_SHIFT (BIN_SHIFT),
    .CNT_W     (CNT_W),
    .TS_W      (TS_W)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (clear),
    .i_inc_en  (w_upd_valid),
    .i_delta   (w_smp_delta),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  assign m_axis.tvalid  = r_tvalid;
  assign m_axis.tdata   = r_tdata;
  assign m_axis.tlast   = r_tlast;
  assign m_axis_tuser   = r_tuser;
  assign stat_min       = r_min;
  assign stat_max       = r_max;
  assign stat_sum       = r_sum;
  assign stat_count     = r_count;
  assign stat_neg_count = r_neg_count;

endmodule

// File: tb/tb_latency_stats_collector.sv
// Directed bench for latency_stats_collector; a second instance with 4-bit
// counters exercises saturation.
module tb_latency_stats_collector;
  import latency_stats_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  latency_stats_collector_if s_if ();
  latency_stats_collector_if m_if ();
  latency_stats_collector_if s2_if ();
  latency_stats_collector_if m2_if ();

  logic [63:0] pl_now;
  logic [63:0] m_tuser, st_min, st_max, m2_tuser, st2_min, st2_max;
  logic [63:0] st_sum, st2_sum;
  logic        clear, freeze;
  logic [3:0]  rd_addr, rd_addr2;
  logic [31:0] rd_data, st_count, st_neg;
  logic [3:0]  rd_data2, st2_count, st2_neg;

  int passed = 0;
  int total  = 0;
  localparam logic [63:0] ONES64 = {64{1'b1}};

  latency_stats_collector dut (
    .clk(clk), .rst(rst), .s_axis(s_if.slave), .pl_now(pl_now),
    .m_axis(m_if.master), .m_axis_tuser(m_tuser), .clear(clear), .freeze(freeze),
    .rd_addr(rd_addr), .rd_data(rd_data), .stat_min(st_min), .stat_max(st_max),
    .stat_sum(st_sum), .stat_count(st_count), .stat_neg_count(st_neg)
  );

  latency_stats_collector #(.CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .s_axis(s2_if.slave), .pl_now(pl_now),
    .m_axis(m2_if.master), .m_axis_tuser(m2_tuser), .clear(clear), .freeze(freeze),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .stat_min(st2_min), .stat_max(st2_max),
    .stat_sum(st2_sum), .stat_count(st2_count), .stat_neg_count(st2_neg)
  );

  function automatic logic [255:0] mk_rec(input logic [63:0] ts, input logic [31:0] tag);
    return {tag, 160'h0, ts};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (m_if.tvalid !== 1'b0) $display("FAIL reset_tvalid got %0b want 0", m_if.tvalid); else passed++;
    total++; if (m_if.tdata !== '0) $display("FAIL reset_tdata got %h want 0", m_if.tdata); else passed++;
    total++; if (m_tuser !== 64'd0) $display("FAIL reset_tuser got %0d want 0", m_tuser); else passed++;
    total++; if (m_if.tlast !== 1'b0) $display("FAIL reset_tlast got %0b want 0", m_if.tlast); else passed++;
    total++; if (st_min !== ONES64) $display("FAIL reset_min got %h want all-ones", st_min); else passed++;
    total++; if (st_max !== 64'd0) $display("FAIL reset_max got %0d want 0", st_max); else passed++;
    total++; if (st_sum !== 64'd0) $display("FAIL reset_sum got %0d want 0", st_sum); else passed++;
    total++; if (st_count !== 32'd0) $display("FAIL reset_count got %0d want 0", st_count); else passed++;
    total++; if (st_neg !== 32'd0) $display("FAIL reset_neg got %0d want 0", st_neg); else passed++;
    total++; if (rd_data !== 32'd0) $display("FAIL reset_rd_data got %0d want 0", rd_data); else passed++;
    total++; if (s_if.tready !== 1'b1) $display("FAIL reset_tready got %0b want 1", s_if.tready); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    pl_now = 64'd350; m_if.tready = 1'b1;
    s_if.tdata = mk_rec(64'd100, 32'hA1); s_if.tlast = 1'b1; s_if.tvalid = 1'b1;
    @(negedge clk);
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    total++; if (m_if.tvalid !== 1'b1) $display("FAIL single_tvalid got %0b want 1", m_if.tvalid); else passed++;
    total++; if (m_tuser !== 64'd250) $display("FAIL single_tuser got %0d want 250", m_tuser); else passed++;
    total++; if (m_if.tdata !== mk_rec(64'd100, 32'hA1)) $display("FAIL single_tdata got %h want %h", m_if.tdata, mk_rec(64'd100, 32'hA1)); else passed++;
    total++; if (m_if.tlast !== 1'b1) $display("FAIL single_tlast got %0b want 1", m_if.tlast); else passed++;
    rd_addr = 4'd15;
    @(negedge clk);
    total++; if (st_count !== 32'd1) $display("FAIL single_count got %0d want 1", st_count); else passed++;
    total++; if (st_min !== 64'd250) $display("FAIL single_min got %0d want 250", st_min); else passed++;
    total++; if (st_max !== 64'd250) $display("FAIL single_max got %0d want 250", st_max); else passed++;
    total++; if (st_sum !== 64'd250) $display("FAIL single_sum got %0d want 250", st_sum); else passed++;
    @(negedge clk);
    total++; if (rd_data !== 32'd1) $display("FAIL single_bin15 got %0d want 1", rd_data); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] lat [3];
    logic [31:0] bins_exp [3];
    lat[0] = 64'd5; lat[1] = 64'd40; lat[2] = 64'd17;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    pl_now = 64'd1000;
    for (int i = 0; i < 3; i++) begin
      total++; if (s_if.tready !== 1'b1) $display("FAIL b2b_tready[%0d] got %0b want 1", i, s_if.tready); else passed++;
      s_if.tdata = mk_rec(64'd1000 - lat[i], 32'(i)); s_if.tvalid = 1'b1;
      @(negedge clk);
      total++; if (m_tuser !== lat[i]) $display("FAIL b2b_tuser[%0d] got %0d want %0d", i, m_tuser, lat[i]); else passed++;
    end
    s_if.tvalid = 1'b0;
    @(negedge clk);
    total++; if (st_min !== 64'd5) $display("FAIL b2b_min got %0d want 5", st_min); else passed++;
    total++; if (st_max !== 64'd40) $display("FAIL b2b_max got %0d want 40", st_max); else passed++;
    total++; if (st_sum !== 64'd62) $display("FAIL b2b_sum got %0d want 62", st_sum); else passed++;
    total++; if (st_count !== 32'd3) $display("FAIL b2b_count got %0d want 3", st_count); else passed++;
    bins_exp[0] = 32'd1; bins_exp[1] = 32'd1; bins_exp[2] = 32'd1;
    for (int b = 0; b < 3; b++) begin
      rd_addr = 4'(b);
      @(negedge clk);
      total++; if (rd_data !== bins_exp[b]) $display("FAIL b2b_bin%0d got %0d want %0d", b, rd_data, bins_exp[b]); else passed++;
    end
  endtask

  task automatic test_negative();
    pl_now = 64'd400;
    s_if.tdata = mk_rec(64'd500, 32'hBE); s_if.tvalid = 1'b1;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    total++; if (m_if.tvalid !== 1'b1) $display("FAIL neg_tvalid got %0b want 1", m_if.tvalid); else passed++;
    total++; if (m_tuser !== 64'd0) $display("FAIL neg_tuser got %0d want 0", m_tuser); else passed++;
    @(negedge clk);
    total++; if (st_neg !== 32'd1) $display("FAIL neg_neg_count got %0d want 1", st_neg); else passed++;
    total++; if (st_count !== 32'd3) $display("FAIL neg_count got %0d want 3", st_count); else passed++;
    total++; if (st_min !== 64'd5) $display("FAIL neg_min got %0d want 5", st_min); else passed++;
    total++; if (st_max !== 64'd40) $display("FAIL neg_max got %0d want 40", st_max); else passed++;
    total++; if (st_sum !== 64'd62) $display("FAIL neg_sum got %0d want 62", st_sum); else passed++;
  endtask

  task automatic test_backpressure();
    pl_now = 64'd1000; m_if.tready = 1'b0;
    s_if.tdata = mk_rec(64'd990, 32'hB0); s_if.tvalid = 1'b1;
    @(negedge clk);
    total++; if (m_tuser !== 64'd10) $display("FAIL bp_tuser got %0d want 10", m_tuser); else passed++;
    for (int c = 0; c < 4; c++) begin
      total++; if (s_if.tready !== 1'b0) $display("FAIL bp_tready[%0d] got %0b want 0", c, s_if.tready); else passed++;
      total++; if (m_if.tvalid !== 1'b1) $display("FAIL bp_tvalid[%0d] got %0b want 1", c, m_if.tvalid); else passed++;
      total++; if (m_if.tdata !== mk_rec(64'd990, 32'hB0)) $display("FAIL bp_tdata[%0d] got %h", c, m_if.tdata); else passed++;
      @(negedge clk);
    end
    s_if.tvalid = 1'b0; m_if.tready = 1'b1;
    @(negedge clk);
    total++; if (m_if.tvalid !== 1'b0) $display("FAIL bp_drain_tvalid got %0b want 0", m_if.tvalid); else passed++;
    total++; if (st_count !== 32'd4) $display("FAIL bp_count got %0d want 4", st_count); else passed++;
    total++; if (st_sum !== 64'd72) $display("FAIL bp_sum got %0d want 72", st_sum); else passed++;
  endtask

  task automatic test_clear_freeze();
    pl_now = 64'd1000;
    s_if.tdata = mk_rec(64'd993, 32'hC0); s_if.tvalid = 1'b1;
    @(negedge clk);
    s_if.tvalid = 1'b0; clear = 1'b1;
    total++; if (m_tuser !== 64'd7) $display("FAIL clr_tuser got %0d want 7", m_tuser); else passed++;
    @(negedge clk);
    clear = 1'b0;
    total++; if (st_count !== 32'd0) $display("FAIL clr_count got %0d want 0", st_count); else passed++;
    total++; if (st_min !== ONES64) $display("FAIL clr_min got %h want all-ones", st_min); else passed++;
    total++; if (st_max !== 64'd0) $display("FAIL clr_max got %0d want 0", st_max); else passed++;
    total++; if (st_sum !== 64'd0) $display("FAIL clr_sum got %0d want 0", st_sum); else passed++;
    total++; if (st_neg !== 32'd0) $display("FAIL clr_neg got %0d want 0", st_neg); else passed++;
    rd_addr = 4'd0;
    @(negedge clk);
    total++; if (rd_data !== 32'd0) $display("FAIL clr_bin0 got %0d want 0", rd_data); else passed++;
    freeze = 1'b1;
    s_if.tdata = mk_rec(64'd980, 32'hF0); s_if.tvalid = 1'b1;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    total++; if (m_if.tvalid !== 1'b1) $display("FAIL frz_tvalid got %0b want 1", m_if.tvalid); else passed++;
    total++; if (m_tuser !== 64'd20) $display("FAIL frz_tuser got %0d want 20", m_tuser); else passed++;
    @(negedge clk);
    freeze = 1'b0;
    @(negedge clk);
    total++; if (st_count !== 32'd0) $display("FAIL frz_count got %0d want 0", st_count); else passed++;
    total++; if (st_sum !== 64'd0) $display("FAIL frz_sum got %0d want 0", st_sum); else passed++;
    total++; if (st_min !== ONES64) $display("FAIL frz_min got %h want all-ones", st_min); else passed++;
    rd_addr = 4'd1;
    @(negedge clk);
    total++; if (rd_data !== 32'd0) $display("FAIL frz_bin1 got %0d want 0", rd_data); else passed++;
  endtask

  task automatic test_saturation();
    pl_now = 64'd1000; m2_if.tready = 1'b1;
    s2_if.tdata = mk_rec(64'd950, 32'h5A); s2_if.tvalid = 1'b1;
    repeat (15) @(negedge clk);
    s2_if.tvalid = 1'b0;
    @(negedge clk);
    total++; if (st2_count !== 4'hF) $display("FAIL sat_count15 got %0d want 15", st2_count); else passed++;
    total++; if (st2_sum !== 64'd750) $display("FAIL sat_sum15 got %0d want 750", st2_sum); else passed++;
    total++; if (st2_min !== 64'd50) $display("FAIL sat_min got %0d want 50", st2_min); else passed++;
    s2_if.tvalid = 1'b1;
    @(negedge clk);
    s2_if.tvalid = 1'b0;
    rd_addr2 = 4'd3;
    @(negedge clk);
    total++; if (st2_count !== 4'hF) $display("FAIL sat_count_hold got %0d want 15", st2_count); else passed++;
    total++; if (st2_sum !== 64'd800) $display("FAIL sat_sum got %0d want 800", st2_sum); else passed++;
    @(negedge clk);
    total++; if (rd_data2 !== 4'hF) $display("FAIL sat_bin3 got %0d want 15", rd_data2); else passed++;
  endtask

  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; m_if.tready = 1'b1;
    s2_if.tvalid = 1'b0; s2_if.tdata = '0; s2_if.tlast = 1'b0; m2_if.tready = 1'b1;
    pl_now = '0; clear = 1'b0; freeze = 1'b0; rd_addr = '0; rd_addr2 = '0; rst = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_negative();
    test_backpressure();
    test_clear_freeze();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/latency_stats_collector.md
Name: latency_stats_collector

Overview:
Parametrised successor to the stage-3 single-shot latency measurement. Accepts the 256-bit event record stream, timestamps each accepted record against the PL timestamp counter, and forwards the record with its latency attached. Keeps running min/max/sum/count statistics and a linear latency histogram, readable through a registered read port. Sits between the record unpacker input stream and downstream book logic, replacing the ILA-only latency probe.

Parameters:
DATA_W, 256, record width in bits
TS_W, 64, timestamp and latency width
TS_LSB, 0, bit offset of the ts_ns field inside the record
NUM_BINS, 16, histogram bin count (power of two, ≥2)
BIN_SHIFT, 4, bin width = 2**BIN_SHIFT ticks
CNT_W, 32, width of the count, neg_count and per-bin counters
SUM_W, 64, latency sum accumulator width

Ports:
clk  in  1  single clock domain
rst  in  1  asynchronous, active-high reset
s_axis_tdata  in  DATA_W  input record
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input last
pl_now  in  TS_W  current PL timestamp
m_axis_tdata  out  DATA_W  forwarded record
m_axis_tuser  out  TS_W  latency of the forwarded record
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  forwarded tlast
clear  in  1  single-cycle pulse: zero all statistics
freeze  in  1  level: hold statistics, forwarding continues
rd_addr  in  $clog2(NUM_BINS)  histogram bin select
rd_data  out  CNT_W  bin count, 1-cycle read latency
stat_min  out  TS_W  minimum valid latency
stat_max  out  TS_W  maximum valid latency
stat_sum  out  SUM_W  saturating latency sum
stat_count  out  CNT_W  valid samples counted
stat_neg_count  out  CNT_W  samples with ts > pl_now

Behaviour:
- Reset (async assert, sync release): m_axis_tvalid=0, m_axis_tdata/tuser/tlast=0, stat_min=all-ones, stat_max/sum/count/neg_count=0, all bins=0, rd_data=0.
- Forward stage: one output register; s_axis_tready = !m_axis_tvalid || m_axis_tready. Accept = s_axis_tvalid && s_axis_tready. Accepted data appears on m_axis the next cycle. Output holds stable while tvalid && !tready. Full throughput, one record per cycle.
- Latency at accept: ts = s_axis_tdata[TS_LSB +: TS_W]; if pl_now >= ts then delta = pl_now - ts (modulo TS_W) and the sample is valid. Otherwise delta = 0, the sample is negative, m_axis_tuser = 0.
- Stats update: registered, visible 1 cycle after accept (sample pipeline register), independent of downstream backpressure.
- Valid sample: count+1; sum+delta; min = min(min, delta); max = max(max, delta); bin[min(delta>>BIN_SHIFT, NUM_BINS-1)] +1. The last bin is the overflow bin.
- Negative sample: neg_count+1 only. No min/max/sum/histogram update.
- Saturation: every counter sticks at all-ones, and sum sticks at all-ones on overflow. Stats never wrap.
- freeze=1: samples arriving at the update stage are discarded. Outputs and the read port stay live.
- clear: all stats return to reset values on the cycle after the pulse. If clear coincides with a pending update, clear wins and that sample is discarded. clear does not affect the forward stage.
- Read port: rd_data <= bin[rd_addr] each cycle, 1-cycle latency. If the same bin is written in the same cycle, the pre-update value is returned.
- Reset mid-transfer: the in-flight output record is dropped and m_axis_tvalid deasserts immediately.

Decomposition:
- Package latency_stats_pkg: default widths, NUM_BINS/BIN_SHIFT constants, a lat_sample_t struct {delta, valid, neg}, and a function for saturating increment.
- Sub-module latency_histogram: bin index clamp, counter array, saturating increment, clear, and registered read port. Parameters NUM_BINS, BIN_SHIFT, CNT_W, TS_W.

Test Plan:
- Reset, then a record with ts=100 at pl_now=350 and m_axis_tready=1 → next cycle tuser=250. Stats cycle after: count=1, min=max=sum=250, bin[15]=1 (250>>4=15).
- Three back-to-back records with latencies 5, 40, 17, tready=1 → min=5, max=40, sum=62, count=3, bin0=1, bin1=1, bin2=1, s_axis_tready stays 1 throughout.
- ts=500 at pl_now=400 → tuser=0, neg_count=1, count/min/max/bins unchanged.
- m_axis_tready=0 for 4 cycles with tvalid held high upstream → exactly one record is captured, s_axis_tready=0, the output stays stable, and the stats update only once.
- clear pulsed in the same cycle as a sample's update → all stats at reset values and the sample is not counted. A freeze=1 sample is not counted either, while its record is still forwarded.
- Force bin[3] and count to all-ones, then send latency 50 → both stay all-ones and sum increments by 50.
